// File: rtl/alu_sequencer_if.sv
// Handshake bundle between the ALU control unit (master) and alu_sequencer (slave).
interface alu_sequencer_if #(parameter int CNT_W = 4);
    logic             start;
    logic [1:0]       opcode;
    logic             q0;
    logic             q_m1;
    logic             a_msb;
    logic [7:0]       cs;
    logic             stop;
    logic             busy;
    logic [CNT_W-1:0] iter;
    logic             err;

    modport master (output start, opcode, q0, q_m1, a_msb,
                    input  cs, stop, busy, iter, err);
    modport slave  (input  start, opcode, q0, q_m1, a_msb,
                    output cs, stop, busy, iter, err);
endinterface

// File: rtl/alu_sequencer.sv
// One-hot control-state generator for the ALU datapath: add, sub, Booth multiply, non-restoring divide.
// Define ALU_SEQ_DIV_EN to compile divide sequencing; without it opcode 11 is skipped and flags err.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_sequencer_if.slave bus
);

    typedef enum logic [7:0] {
        S_IDLE  = 8'h01,
        S_LOAD  = 8'h02,
        S_ADD   = 8'h04,
        S_SUB   = 8'h08,
        S_SHIFT = 8'h10,
        S_STORE = 8'h20,
        S_EVAL  = 8'h40,
        S_DONE  = 8'h80
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_iter;
    logic [CNT_W-1:0] w_iter_dec;
    logic             w_last;
    logic             r_stop;
    logic             r_busy;
    logic             r_err;
`ifdef ALU_SEQ_DIV_EN
    logic             r_dsign;
`else
    logic             w_unused_a_msb;
    assign w_unused_a_msb = bus.a_msb;
`endif

    // Saturating decrement keeps iter from wrapping below zero.
    assign w_iter_dec = (r_iter == '0) ? '0 : r_iter - 1'b1;
    assign w_last     = (w_iter_dec == '0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LOAD;
            S_LOAD: begin
                case (r_op)
                    OP_ADD:  w_next = S_ADD;
                    OP_SUB:  w_next = S_SUB;
                    OP_MUL:  w_next = S_EVAL;
`ifdef ALU_SEQ_DIV_EN
                    default: w_next = S_EVAL;
`else
                    default: w_next = S_STORE;
`endif
                endcase
            end
            S_ADD, S_SUB: begin
                if (r_op == OP_MUL)
                    w_next = S_SHIFT;
`ifdef ALU_SEQ_DIV_EN
                else if (r_op == OP_DIV)
                    w_next = w_last ? S_STORE : S_EVAL;
`endif
                else
                    w_next = S_STORE;
            end
            S_SHIFT: begin
`ifdef ALU_SEQ_DIV_EN
                if (r_op == OP_DIV)
                    w_next = r_dsign ? S_ADD : S_SUB;
                else
`endif
                    w_next = w_last ? S_STORE : S_EVAL;
            end
            S_EVAL: begin
`ifdef ALU_SEQ_DIV_EN
                if (r_op == OP_DIV)
                    w_next = S_SHIFT;
                else
`endif
                case ({bus.q0, bus.q_m1})
                    2'b10:   w_next = S_SUB;
                    2'b01:   w_next = S_ADD;
                    default: w_next = S_SHIFT;
                endcase
            end
            S_STORE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // stop/busy are derived from the next state so they line up with cs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_iter  <= '0;
            r_err   <= 1'b0;
            r_op    <= OP_ADD;
`ifdef ALU_SEQ_DIV_EN
            r_dsign <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_stop  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.opcode;
                        r_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_iter <= CNT_W'(WIDTH);
`ifndef ALU_SEQ_DIV_EN
                    if (r_op == OP_DIV) r_err <= 1'b1;
`endif
                end
`ifdef ALU_SEQ_DIV_EN
                S_ADD, S_SUB: if (r_op == OP_DIV) r_iter <= w_iter_dec;
                S_EVAL:       if (r_op == OP_DIV) r_dsign <= bus.a_msb;
`endif
                S_SHIFT: if (r_op == OP_MUL) r_iter <= w_iter_dec;
                default: ;
            endcase
        end
    end

    assign bus.cs   = r_state;
    assign bus.stop = r_stop;
    assign bus.busy = r_busy;
    assign bus.iter = r_iter;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural datapath plus an arithmetic reference model.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.CNT_W(4)) bus ();

    alu_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  dp_op;
    logic [7:0]  dp_a, dp_b;
    logic [7:0]  ra, rq, rm;
    logic        rq1;
    logic [15:0] rr, res_st;
    logic [7:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Datapath reacts at the edge that ends the cycle in which cs was c.
    task automatic dp_update(input logic [7:0] c);
        case (c)
            8'h02: begin
                rq1 = 1'b0;
                if (dp_op == 2'b10)      begin ra = 8'h00; rq = dp_b; rm = dp_a; end
                else if (dp_op == 2'b11) begin ra = 8'h00; rq = dp_a; rm = dp_b; end
                else                     begin ra = dp_a;  rq = 8'h00; rm = dp_b; end
            end
            8'h04: begin
                if (dp_op[1] == 1'b0) rr = {{8{ra[7]}}, ra} + {{8{rm[7]}}, rm};
                else begin
                    ra = ra + rm;
                    if (dp_op == 2'b11) rq[0] = ~ra[7];
                end
            end
            8'h08: begin
                if (dp_op[1] == 1'b0) rr = {{8{ra[7]}}, ra} - {{8{rm[7]}}, rm};
                else begin
                    ra = ra - rm;
                    if (dp_op == 2'b11) rq[0] = ~ra[7];
                end
            end
            8'h10: begin
                if (dp_op == 2'b10)      {ra, rq, rq1} = {ra[7], ra, rq};
                else if (dp_op == 2'b11) {ra, rq} = {ra[6:0], rq, 1'b0};
            end
            8'h20: res_st = (dp_op == 2'b10) ? {ra, rq} : (dp_op == 2'b11) ? {8'h00, rq} : rr;
            default: ;
        endcase
        bus.q0    = rq[0];
        bus.q_m1  = rq1;
        bus.a_msb = ra[7];
    endtask

    task automatic cyc();
        logic [7:0] c;
        c = bus.cs;
        @(posedge clk);
        #1;
        dp_update(c);
    endtask

    // Expected LOAD..DONE state list from operand arithmetic.
    task automatic build_exp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic pr;
        int   r, d;
        exp_q.delete();
        exp_q.push_back(8'h02);
        case (op)
            2'b00: exp_q.push_back(8'h04);
            2'b01: exp_q.push_back(8'h08);
            2'b10: begin
                pr = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    exp_q.push_back(8'h40);
                    if (b[i] && !pr)      exp_q.push_back(8'h08);
                    else if (!b[i] && pr) exp_q.push_back(8'h04);
                    exp_q.push_back(8'h10);
                    pr = b[i];
                end
            end
            default: begin
                if (DIV_EN) begin
                    r = 0;
                    d = int'(b);
                    for (int i = 7; i >= 0; i--) begin
                        exp_q.push_back(8'h40);
                        exp_q.push_back(8'h10);
                        if (r < 0) begin r = 2 * r + int'(a[i]) + d; exp_q.push_back(8'h04); end
                        else       begin r = 2 * r + int'(a[i]) - d; exp_q.push_back(8'h08); end
                    end
                end
            end
        endcase
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h80);
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [7:0] b);
        int k;
        logic [8:0] bx;
        bx = {b, 1'b0};
        k = 0;
        for (int i = 0; i < 8; i++) if (bx[i+1] != bx[i]) k++;
        case (op)
            2'b00, 2'b01: return 4;
            2'b10:        return 19 + k;
            default:      return DIV_EN ? 27 : 3;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic hold, input int chg_at);
        int lat, nsh, sa, sb;
        logic [7:0]  c;
        logic [15:0] exp_r;
        dp_op = op; dp_a = a; dp_b = b;
        build_exp(op, a, b);
        chk({tag, "_idle_before"}, bus.cs, 8'h01);
        bus.opcode = op;
        bus.start  = 1'b1;
        cyc();
        chk({tag, "_err_at_load"}, bus.err, 1'b0);
        lat = 0; nsh = 0;
        while (bus.cs != 8'h01 && lat < 64) begin
            lat++;
            if (lat <= exp_q.size()) begin
                chk({tag, "_cs"},   bus.cs,   exp_q[lat-1]);
                chk({tag, "_stop"}, bus.stop, exp_q[lat-1] == 8'h80);
            end else
                chk({tag, "_overrun"}, lat, exp_q.size());
            chk({tag, "_busy"}, bus.busy, 1'b1);
            if (bus.cs == 8'h10) nsh++;
            if (lat == chg_at) bus.opcode = ~op;
            c = bus.cs;
            cyc();
            if (c == 8'h80 && !hold) bus.start = 1'b0;
        end
        chk({tag, "_latency"}, lat, exp_lat(op, b));
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
        chk({tag, "_idle_stop"}, bus.stop, 1'b0);
        chk({tag, "_iter"}, bus.iter, (op == 2'b10 || (op == 2'b11 && DIV_EN)) ? 0 : 8);
        chk({tag, "_err"}, bus.err, (op == 2'b11 && !DIV_EN));
        if (op == 2'b10) chk({tag, "_shifts"}, nsh, 8);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'b00:   exp_r = 16'(sa + sb);
            2'b01:   exp_r = 16'(sa - sb);
            2'b10:   exp_r = 16'(sa * sb);
            default: exp_r = 16'(int'(a) / int'(b));
        endcase
        if (op != 2'b11 || DIV_EN) chk({tag, "_result"}, res_st, exp_r);
    endtask

    initial begin
        int nsh, guard;
        logic [1:0] rop;
        logic [7:0] ra_r, rb_r;
        rst = 1'b1;
        bus.start = 1'b0; bus.opcode = 2'b00;
        bus.q0 = 1'b0; bus.q_m1 = 1'b0; bus.a_msb = 1'b0;
        ra = 0; rq = 0; rm = 0; rq1 = 0; rr = 0; res_st = 0;
        dp_op = 0; dp_a = 0; dp_b = 0;
        repeat (3) cyc();
        chk("reset_cs",   bus.cs,   8'h01);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_stop", bus.stop, 1'b0);
        chk("reset_iter", bus.iter, 4'd0);
        chk("reset_err",  bus.err,  1'b0);
        rst = 1'b0;
        cyc();

        run_op("add",      2'b00, 8'd5,   8'd9,   1'b0, 0);
        run_op("sub",      2'b01, 8'd5,   8'd9,   1'b0, 0);
        run_op("mul_3xm2", 2'b10, 8'd3,   8'hFE,  1'b0, 0);
        run_op("mul_q0",   2'b10, 8'h5A,  8'h00,  1'b0, 0);
        run_op("div",      2'b11, 8'd100, 8'd7,   1'b0, 0);

        // Reset during the 5th SHIFT of a multiply.
        dp_op = 2'b10; dp_a = 8'h55; dp_b = 8'hA7;
        bus.opcode = 2'b10; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        nsh = 0; guard = 0;
        while (nsh < 5 && guard < 64) begin
            if (bus.cs == 8'h10) nsh++;
            if (nsh < 5) begin cyc(); guard++; end
        end
        chk("rst_mid_reach", nsh, 5);
        rst = 1'b1;
        cyc();
        chk("rst_mid_cs",   bus.cs,   8'h01);
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_iter", bus.iter, 4'd0);
        chk("rst_mid_stop", bus.stop, 1'b0);
        rst = 1'b0;
        cyc();

        // Held start with opcode changed mid-operation; next op starts after the IDLE cycle.
        run_op("hold_mul", 2'b10, 8'd3, 8'hFE, 1'b1, 3);
        run_op("hold_add", 2'b00, 8'd7, 8'd8,  1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'b11) begin
                ra_r = 8'($urandom_range(0, 127));
                rb_r = 8'($urandom_range(1, 63));
            end else begin
                ra_r = 8'($urandom);
                rb_r = 8'($urandom);
            end
            run_op("rand", rop, ra_r, rb_r, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-state generator for the 8-bit ALU datapath and its control unit.
- Produces the one-hot control word cs[7:0] that the control unit decodes into load, add, sub, shift and store actions.
- Sequences four operations: add, subtract, Booth multiply and non-restoring divide.
- Handshakes with the control unit's start/stop pair and counts the iterations of multiply and divide.

Parameters:
WIDTH, 8, operand width; number of multiply/divide iterations.
CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  level request from the control unit; sampled only in IDLE.
opcode  input  2  operation select: 00 add, 01 sub, 10 mult, 11 div. Captured in IDLE when start=1.
q0  input  1  current Q[0] of the datapath.
q_m1  input  1  current Q1 (Booth extra bit) of the datapath.
a_msb  input  1  current A[WIDTH-1] (sign of the partial remainder).
cs  output  8  one-hot control word; this is the state register itself.
stop  output  1  high for exactly the DONE cycle.
busy  output  1  high in every state except IDLE.
iter  output  CNT_W  remaining iteration count.
err  output  1  illegal-operation flag (see Optional Feature).

Behaviour:
- cs encoding, exactly one bit set every cycle:
  - cs[0] IDLE, cs[1] LOAD, cs[2] ADD, cs[3] SUB
  - cs[4] SHIFT, cs[5] STORE, cs[6] EVAL, cs[7] DONE
- Reset (sync, any state, including mid-operation), all on the next edge:
  - cs=8'h01, stop=0, busy=0, iter=0, err=0, latched opcode=00, dsign=0.
- IDLE:
  - start=1: latch opcode, go to LOAD.
  - start=0: stay in IDLE.
  - start is ignored in every other state; a new request during an operation is not lost, because the control unit holds start high until it is serviced in IDLE.
- LOAD: iter<=WIDTH. Next state is ADD (op 00), SUB (op 01) or EVAL (op 10/11).
- Add/sub: ADD or SUB -> STORE. Total of 4 busy cycles: LOAD, op, STORE, DONE.
- Multiply (Booth, radix-2):
  - EVAL decodes {q0,q_m1}: 10 -> SUB, 01 -> ADD, 00/11 -> SHIFT directly.
  - ADD/SUB -> SHIFT.
  - SHIFT: iter<=iter-1. If the decremented value is 0, go to STORE; otherwise go to EVAL.
  - EVAL exists so that the decision always sees post-shift q0/q_m1; the datapath registers update at the SHIFT edge.
- Divide (non-restoring):
  - EVAL: dsign<=a_msb, then go to SHIFT.
  - SHIFT: go to ADD if dsign=1, otherwise SUB.
  - ADD/SUB: iter<=iter-1. If the decremented value is 0, go to STORE; otherwise go to EVAL.
  - The datapath sets Q[0] from the add/sub result sign.
  - No remainder correction step; the quotient is final.
- STORE -> DONE.
- DONE:
  - stop=1 for this single cycle, then go to IDLE.
  - The control unit clears start on that same edge.
- Latency from LOAD to DONE inclusive:
  - add/sub: 4 cycles.
  - mult: 3 + 2*WIDTH + (number of iterations with {q0,q_m1} equal to 01 or 10), i.e. 19..27 cycles for WIDTH=8.
  - div: 3 + 3*WIDTH = 27 cycles.
- iter:
  - Holds its value through STORE, DONE and IDLE.
  - Is never decremented below 0.
  - Is reloaded only in LOAD.
- busy = ~cs[0], registered consistently with cs (no combinational glitch).
- The latched opcode, not the live opcode input, steers every decision after IDLE. Changing the opcode input mid-operation has no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: divide sequencing exactly as above; err is held at 0.
- Undefined:
  - No divide states or dsign register are compiled.
  - opcode 11 runs LOAD -> STORE -> DONE, 3 cycles, with no ADD/SUB/SHIFT issued.
  - err is set high at LOAD and cleared on the next accepted start or on reset.

Test Plan:
- Reset then add: opcode=00, start pulse -> cs sequence 01,02,04,20,80,01; stop=1 only in the 80 cycle; busy high for exactly 4 cycles.
- Subtract with a behavioural datapath model, A=5, B=9 -> cs sequence 02,08,20,80; result -4 (16'hFFFC); iter ends at 8.
- Multiply 3 x -2 (Q=8'hFE) -> only EVAL/SUB/ADD/SHIFT between LOAD and STORE; exactly 8 SHIFTs; rez=16'hFFFA; cycle count matches the formula.
- Multiply with Q=0 -> no ADD/SUB issued; LOAD to DONE is 19 cycles.
- Divide 100/7 with ALU_SEQ_DIV_EN defined -> 27-cycle sequence; final Q=14; err=0. With the macro undefined -> 3-cycle sequence and err=1.
- Reset asserted in the 5th SHIFT of a multiply -> next cycle cs=01, busy=0, iter=0. A start held high with opcode changed mid-operation -> new operation begins only in the IDLE cycle after DONE.
